// File: rtl/banked_regfile.sv
// rtl/banked_regfile.sv - 31-entry banked register file: two read ports, one write port, R15 program counter.
// Same-cycle read/write returns the new value when REGFILE_BYPASS_EN is defined, the old value otherwise.
module banked_regfile #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [4:0]  ra_idx,
  input  logic [4:0]  rb_idx,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  output logic        rvalid,
  input  logic        we,
  input  logic [4:0]  w_idx,
  input  logic [31:0] w_data,
  input  logic        pc_inc,
  output logic [31:0] pc_out
);

  localparam int NUM_REGS = 31;
  localparam int PC_IDX   = 15;

  logic [31:0] regs      [0:NUM_REGS-1];
  logic [31:0] next_regs [0:NUM_REGS-1];
  logic [31:0] pc_next;
  logic [31:0] src_a;
  logic [31:0] src_b;

  // R15 write beats the auto-increment; index 31 never matches a stored entry
  always_comb begin
    if (we && (w_idx == 5'(PC_IDX))) begin
      pc_next = w_data;
    end else if (pc_inc) begin
      pc_next = regs[PC_IDX] + 32'd4;
    end else begin
      pc_next = regs[PC_IDX];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      next_regs[i] = regs[i];
      if (we && (w_idx == 5'(i))) begin
        next_regs[i] = w_data;
      end
    end
    next_regs[PC_IDX] = pc_next;
  end

  always_comb begin
    src_a = 32'h0000_0000;
    src_b = 32'h0000_0000;
`ifdef REGFILE_BYPASS_EN
    if (ra_idx != 5'd31) src_a = next_regs[ra_idx];
    if (rb_idx != 5'd31) src_b = next_regs[rb_idx];
`else
    if (ra_idx != 5'd31) src_a = regs[ra_idx];
    if (rb_idx != 5'd31) src_b = regs[rb_idx];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == PC_IDX) ? RESET_PC : 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= next_regs[i];
      end
    end
  end

  // Read data holds across idle cycles; only rvalid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_data <= 32'h0000_0000;
      rb_data <= 32'h0000_0000;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        ra_data <= src_a;
        rb_data <= src_b;
      end
    end
  end

  assign pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_banked_regfile.sv
// tb/tb_banked_regfile.sv - directed and random checks of banked_regfile against an array-based model.
module tb_banked_regfile;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  ra_idx = '0;
  logic [4:0]  rb_idx = '0;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        rvalid;
  logic        we = 1'b0;
  logic [4:0]  w_idx = '0;
  logic [31:0] w_data = '0;
  logic        pc_inc = 1'b0;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [0:31];
  logic [31:0] exp_ra = '0;
  logic [31:0] exp_rb = '0;
  logic        exp_rv = 1'b0;

  banked_regfile #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .ra_idx(ra_idx), .rb_idx(rb_idx),
    .ra_data(ra_data), .rb_data(rb_data), .rvalid(rvalid), .we(we),
    .w_idx(w_idx), .w_data(w_data), .pc_inc(pc_inc), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[15] = RPC;
    exp_ra = 32'h0;
    exp_rb = 32'h0;
    exp_rv = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rvalid"}, {31'h0, rvalid}, {31'h0, exp_rv});
    check({tag, ".ra"}, ra_data, exp_ra);
    check({tag, ".rb"}, rb_data, exp_rb);
    check({tag, ".pc"}, pc_out, m[15]);
  endtask

  // Drive one edge's worth of inputs (called at posedge+1), advance model, check at posedge+1
  task automatic cycle(input string tag, input logic rd, input logic [4:0] a, input logic [4:0] b,
                       input logic w, input logic [4:0] wi, input logic [31:0] wd, input logic pi);
    logic [31:0] nm [0:31];
    rd_en = rd; ra_idx = a; rb_idx = b; we = w; w_idx = wi; w_data = wd; pc_inc = pi;
    @(posedge clk);
    for (int i = 0; i < 32; i++) nm[i] = m[i];
    if (w && wi != 5'd31) nm[wi] = wd;
    if (!(w && wi == 5'd15) && pi) nm[15] = m[15] + 32'd4;
    if (rd) begin
`ifdef REGFILE_BYPASS_EN
      exp_ra = nm[a];
      exp_rb = nm[b];
`else
      exp_ra = m[a];
      exp_rb = m[b];
`endif
    end
    exp_rv = rd;
    for (int i = 0; i < 32; i++) m[i] = nm[i];
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    check_outputs("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_pc", pc_out, 32'h0000_0100);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);

    for (int i = 0; i <= 30; i++) cycle("reset_read", 1'b1, 5'(i), 5'(30 - i), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle("reset_r15", 1'b1, 5'd15, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("reset_r15_const", ra_data, 32'h0000_0100);

    cycle("bank_w13", 1'b0, 5'd0, 5'd0, 1'b1, 5'd13, 32'hAAAA_0001, 1'b0);
    cycle("bank_w23", 1'b0, 5'd0, 5'd0, 1'b1, 5'd23, 32'hBBBB_0002, 1'b0);
    cycle("bank_rd", 1'b1, 5'd13, 5'd23, 1'b0, 5'd0, 32'h0, 1'b0);
    check("bank_a", ra_data, 32'hAAAA_0001);
    check("bank_b", rb_data, 32'hBBBB_0002);
    check("bank_rvalid", {31'h0, rvalid}, 32'h1);
    cycle("idle_hold", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0);

    cycle("pc_clr", 1'b0, 5'd0, 5'd0, 1'b1, 5'd15, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pc_inc", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("pc_c", pc_out, 32'h0000_000C);
    cycle("pc_wr_pri", 1'b0, 5'd0, 5'd0, 1'b1, 5'd15, 32'h40, 1'b1);
    check("pc_40", pc_out, 32'h0000_0040);
    cycle("pc_top", 1'b0, 5'd0, 5'd0, 1'b1, 5'd15, 32'hFFFF_FFFC, 1'b0);
    cycle("pc_wrap", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    check("pc_wrap0", pc_out, 32'h0);

    cycle("haz_init", 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1, 1'b0);
    cycle("haz", 1'b1, 5'd5, 5'd15, 1'b1, 5'd5, 32'h2, 1'b1);
`ifdef REGFILE_BYPASS_EN
    check("haz_const", ra_data, 32'h2);
    check("haz_pc_const", rb_data, 32'h4);
`else
    check("haz_const", ra_data, 32'h1);
    check("haz_pc_const", rb_data, 32'h0);
`endif

    cycle("r31_w", 1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0);
    cycle("r31_rd", 1'b1, 5'd31, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0);
    check("r31_a", ra_data, 32'h0);
    check("r31_b", rb_data, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wi;
      wi = 5'($urandom_range(0, 31));
      cycle("rand", 1'($urandom), (n % 4 == 0) ? wi : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom), wi, $urandom, 1'($urandom));
    end

    // Back-to-back traffic, then reset lands between edges with a write in flight
    cycle("mid_w", 1'b1, 5'd7, 5'd8, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    cycle("mid_rw", 1'b1, 5'd7, 5'd9, 1'b1, 5'd9, 32'h9ABC_DEF0, 1'b0);
    rd_en = 1'b1; ra_idx = 5'd9; rb_idx = 5'd7; we = 1'b1; w_idx = 5'd20; w_data = 32'h5555_AAAA; pc_inc = 1'b1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs("mid_rst_async");
    @(posedge clk);
    #1;
    check_outputs("mid_rst_edge");
    rst = 1'b0;
    cycle("post_rst_a", 1'b1, 5'd20, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0);
    check("post_rst_w20", ra_data, 32'h0);
    cycle("post_rst_b", 1'b1, 5'd7, 5'd15, 1'b0, 5'd0, 32'h0, 1'b0);
    check("post_rst_pc", rb_data, RPC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
